// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : adc_pkg
//  Description : Shared types and constants for the paced XADC sampler:
//                sequencer state encoding, channel selector type, XADC DRP
//                addresses of the two auxiliary inputs, and the default
//                ring-buffer placement in data RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

  // Sequencer states: one DRP read followed by one RAM write per tick.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Channel being sampled; alternates after every completed or timed-out read.
  typedef enum logic {
    CH_EMG = 1'b0,
    CH_ECG = 1'b1
  } chan_t;

  // XADC status-register addresses for VAUX3 (EMG) and VAUX11 (ECG).
  localparam logic [6:0] EMG_DRP_ADDR = 7'h13;
  localparam logic [6:0] ECG_DRP_ADDR = 7'h1B;

  // Default ring placement: two 640-entry rings in the upper half of RAM.
  localparam int          DEF_BUF_DEPTH = 640;
  localparam logic [11:0] DEF_EMG_BASE  = 12'h800;
  localparam logic [11:0] DEF_ECG_BASE  = 12'hA80;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_sample_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sample_tick_gen
//  Description : Free-running modulo-INTERVAL counter. tick_o is high for one
//                cycle each time the count sits at INTERVAL-1.
//  Ports       : clock_i - system clock
//                reset_i - synchronous active-high reset (count -> 0)
//                tick_o  - sample pacing strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen #(
  parameter int INTERVAL = 175000
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int            CW   = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == LAST);

endmodule : sample_tick_gen
`default_nettype wire

// File: rtl/adc_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_sequencer
//  Description : Paced XADC sampler. Each tick reads one auxiliary channel
//                (EMG and ECG alternate) over the DRP and writes the 12-bit
//                result into that channel's ring buffer in data RAM.
//  Ports       : clock_i, reset_i       - clock, synchronous active-high reset
//                clear_flags_i          - clears the sticky error flags
//                drp_den_o/dwe_o/daddr_o- DRP read request (read-only use)
//                drp_do_i, drp_drdy_i   - DRP read data / valid
//                adc_wEn_o/addr_o/dataIn_o - RAM ADC write port
//                emg_head_o, ecg_head_o - next write index of each ring
//                overrun_o              - sticky: tick arrived while busy
//                timeout_err_o          - sticky: DRP read never answered
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_sequencer
  import adc_pkg::*;
#(
  parameter int          SAMPLE_INTERVAL = 175000,
  parameter int          BUF_DEPTH       = DEF_BUF_DEPTH,
  parameter logic [11:0] EMG_BASE        = DEF_EMG_BASE,
  parameter logic [11:0] ECG_BASE        = DEF_ECG_BASE,
  parameter int          DRP_TIMEOUT     = 255
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear_flags_i,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [6:0]  drp_daddr_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,
  output logic        adc_wEn_o,
  output logic [11:0] adc_addr_o,
  output logic [31:0] adc_dataIn_o,
  output logic [9:0]  emg_head_o,
  output logic [9:0]  ecg_head_o,
  output logic        overrun_o,
  output logic        timeout_err_o
);

  localparam int            TW        = $clog2(DRP_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(DRP_TIMEOUT - 1);
  localparam logic [9:0]    HEAD_LAST = 10'(BUF_DEPTH - 1);

  function automatic logic [9:0] f_next_head(input logic [9:0] head);
    return (head == HEAD_LAST) ? 10'd0 : head + 10'd1;
  endfunction

  logic tick;

  sample_tick_gen #(
    .INTERVAL (SAMPLE_INTERVAL)
  ) u_tick (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .tick_o  (tick)
  );

  state_t        state_q,    state_d;
  chan_t         chan_q,     chan_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [9:0]    emg_head_q, emg_head_d;
  logic [9:0]    ecg_head_q, ecg_head_d;
  logic [11:0]   addr_q,     addr_d;
  logic [31:0]   data_q,     data_d;
  logic          overrun_q,  overrun_d;
  logic          timeout_q,  timeout_d;
  logic          den, wen, ovr_set, to_set;

  // The low nibble of the XADC word is below the 12-bit conversion result.
  logic unused_do_bits;
  assign unused_do_bits = ^drp_do_i[3:0];

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    wait_cnt_d = wait_cnt_q;
    emg_head_d = emg_head_q;
    ecg_head_d = ecg_head_q;
    addr_d     = addr_q;
    data_d     = data_q;
    den        = 1'b0;
    wen        = 1'b0;
    to_set     = 1'b0;
    // A tick that cannot be serviced is dropped; chan is left untouched.
    ovr_set    = tick && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_REQ;
      end
      ST_REQ: begin
        den        = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // drdy on the final wait cycle still counts as a valid answer.
        if (drp_drdy_i) begin
          // Address and data are captured here so they are stable for the
          // whole write cycle and remain valid until the next write.
          data_d = {20'b0, drp_do_i[15:4]};
          if (chan_q == CH_EMG) begin
            addr_d     = EMG_BASE + {2'b00, emg_head_q};
            emg_head_d = f_next_head(emg_head_q);
          end else begin
            addr_d     = ECG_BASE + {2'b00, ecg_head_q};
            ecg_head_d = f_next_head(ecg_head_q);
          end
          state_d = ST_WRITE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          to_set  = 1'b1;
          chan_d  = (chan_q == CH_EMG) ? CH_ECG : CH_EMG;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      ST_WRITE: begin
        wen     = 1'b1;
        chan_d  = (chan_q == CH_EMG) ? CH_ECG : CH_EMG;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new event beats a simultaneous clear.
    overrun_d = ovr_set ? 1'b1 : (clear_flags_i ? 1'b0 : overrun_q);
    timeout_d = to_set  ? 1'b1 : (clear_flags_i ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      chan_q     <= CH_EMG;
      wait_cnt_q <= '0;
      emg_head_q <= '0;
      ecg_head_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      wait_cnt_q <= wait_cnt_d;
      emg_head_q <= emg_head_d;
      ecg_head_q <= ecg_head_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign drp_den_o     = den;
  assign drp_dwe_o     = 1'b0;
  assign drp_daddr_o   = (chan_q == CH_EMG) ? EMG_DRP_ADDR : ECG_DRP_ADDR;
  assign adc_wEn_o     = wen;
  assign adc_addr_o    = addr_q;
  assign adc_dataIn_o  = data_q;
  assign emg_head_o    = emg_head_q;
  assign ecg_head_o    = ecg_head_q;
  assign overrun_o     = overrun_q;
  assign timeout_err_o = timeout_q;

endmodule : adc_sample_sequencer
`default_nettype wire

// File: tb/tb_adc_sample_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sample_sequencer
//  Description : Self-checking bench for adc_sample_sequencer. A DRP responder
//                answers each read after a chosen latency; a transaction-level
//                reference model predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_sequencer;

  localparam int N     = 20;
  localparam int DEPTH = 4;
  localparam int TO    = 30;
  localparam int EMG_B = 'h800;
  localparam int ECG_B = 'hA80;
  localparam int NTAB  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] dout = 16'h0;
  logic        den, dwe, wen, ovr, toe;
  logic [6:0]  daddr;
  logic [11:0] addr;
  logic [31:0] din;
  logic [9:0]  eh, ch;

  always #5 clk = ~clk;

  adc_sample_sequencer #(
    .SAMPLE_INTERVAL (N),
    .BUF_DEPTH       (DEPTH),
    .EMG_BASE        (12'h800),
    .ECG_BASE        (12'hA80),
    .DRP_TIMEOUT     (TO)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .clear_flags_i (clr),
    .drp_den_o     (den),
    .drp_dwe_o     (dwe),
    .drp_daddr_o   (daddr),
    .drp_do_i      (dout),
    .drp_drdy_i    (drdy),
    .adc_wEn_o     (wen),
    .adc_addr_o    (addr),
    .adc_dataIn_o  (din),
    .emg_head_o    (eh),
    .ecg_head_o    (ch),
    .overrun_o     (ovr),
    .timeout_err_o (toe)
  );

  // Directed transactions: DRP latency (0 = never answers) and data, plus the
  // hand-computed RAM write expected from them.
  typedef struct {
    int          lat;
    logic [15:0] data;
    logic        wen;
    logic [11:0] addr;
    logic [31:0] dat;
  } vec_t;
  vec_t tab [NTAB];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  bit          busy;
  int          den_cyc, wr_cyc, end_cyc, drdy_cyc, sched;
  int          chan;
  int          head [2];
  int          last_addr, last_data, exp_addr, exp_data;
  bit          m_ovr, m_to;
  int          tab_idx, tab_ptr, wen_seen, force_lat;
  bit          use_tab, noise_en, clr_en, force_clr;
  logic [15:0] cur_data;
  int          first_wen = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    busy = 1'b0; chan = 0; head[0] = 0; head[1] = 0;
    last_addr = 0; last_data = 0; m_ovr = 1'b0; m_to = 1'b0;
    sched = -1; den_cyc = -1; wr_cyc = -1; end_cyc = -1; drdy_cyc = -1;
    tab_idx = -1; wen_seen = 0;
  endtask

  function automatic bit in_window(input int k);
    int last;
    last = (drdy_cyc >= 0) ? drdy_cyc : end_cyc;
    return busy && (k >= den_cyc + 1) && (k <= last);
  endfunction

  task automatic start_txn(input int k);
    int lat;
    tab_idx = -1;
    if (force_lat >= 0) begin
      lat = force_lat; force_lat = -1; cur_data = 16'($urandom);
    end else if (use_tab && tab_ptr < NTAB) begin
      tab_idx = tab_ptr; lat = tab[tab_ptr].lat; cur_data = tab[tab_ptr].data; tab_ptr++;
    end else begin
      case ($urandom_range(0, 9))
        0:       lat = 0;
        1:       lat = TO + 1;
        2:       lat = TO;
        default: lat = int'($urandom_range(1, 12));
      endcase
      cur_data = 16'($urandom);
    end
    busy = 1'b1; den_cyc = k + 1; wen_seen = 0;
    sched = (lat > 0) ? k + 1 + lat : -1;
    if (lat >= 1 && lat <= TO) begin
      drdy_cyc = k + 1 + lat; wr_cyc = k + 2 + lat; end_cyc = k + 2 + lat;
      exp_addr = ((chan == 0) ? EMG_B : ECG_B) + head[chan];
      exp_data = int'(cur_data[15:4]);
    end else begin
      drdy_cyc = -1; wr_cyc = -1; end_cyc = k + 1 + TO;
    end
  endtask

  task automatic check_cycle();
    bit in_wr;
    in_wr = busy && (cyc == wr_cyc);
    chk("den",     32'(den),   32'(busy && cyc == den_cyc));
    chk("wen",     32'(wen),   32'(in_wr));
    chk("dwe",     32'(dwe),   32'd0);
    chk("daddr",   32'(daddr), (chan == 0) ? 32'h13 : 32'h1B);
    chk("addr",    32'(addr),  32'(last_addr));
    chk("data",    din,        32'(last_data));
    chk("overrun", 32'(ovr),   32'(m_ovr));
    chk("timeout", 32'(toe),   32'(m_to));
    if (!in_wr) begin
      chk("emg_head", 32'(eh), 32'(head[0]));
      chk("ecg_head", 32'(ch), 32'(head[1]));
    end
    if (wen === 1'b1) begin
      wen_seen++;
      if (first_wen < 0) first_wen = cyc;
      if (in_wr && tab_idx >= 0) begin
        chk("tab_addr", 32'(addr), 32'(tab[tab_idx].addr));
        chk("tab_data", din, tab[tab_idx].dat);
      end
    end
  endtask

  task automatic model_advance();
    bit tick, ovr_set, to_set;
    tick    = (cyc % N) == N - 1;
    ovr_set = busy && tick;
    to_set  = 1'b0;
    if (busy && cyc + 1 == wr_cyc) begin
      last_addr = exp_addr; last_data = exp_data;
    end
    if (busy && cyc == end_cyc) begin
      if (wr_cyc < 0) to_set = 1'b1;
      else head[chan] = (head[chan] + 1) % DEPTH;
      if (tab_idx >= 0) chk("tab_wen", 32'(wen_seen), 32'(tab[tab_idx].wen));
      chan = 1 - chan; busy = 1'b0;
    end else if (!busy && tick) begin
      start_txn(cyc);
    end
    m_ovr = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_to  = to_set  ? 1'b1 : (clr ? 1'b0 : m_to);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_den"},   32'(den),   32'd0);
    chk({tag, "_wen"},   32'(wen),   32'd0);
    chk({tag, "_addr"},  32'(addr),  32'd0);
    chk({tag, "_data"},  din,        32'd0);
    chk({tag, "_daddr"}, 32'(daddr), 32'h13);
    chk({tag, "_heads"}, 32'({eh, ch}), 32'd0);
    chk({tag, "_flags"}, 32'({ovr, toe}), 32'd0);
  endtask

  task automatic finish_cycle(input bit rst_check);
    dout = cur_data;
    @(negedge clk);
    if (rst_check) chk_reset_vals("post_rst");
    check_cycle();
    model_advance();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic run_one();
    drdy = (cyc == sched);
    if (!drdy && noise_en && !in_window(cyc) && $urandom_range(0, 5) == 0) drdy = 1'b1;
    clr = force_clr || (clr_en && $urandom_range(0, 19) == 0);
    finish_cycle(1'b0);
  endtask

  initial begin
    tab[0]  = '{3,  16'hABC0, 1'b1, 12'h800, 32'h00000ABC};
    tab[1]  = '{3,  16'h1235, 1'b1, 12'hA80, 32'h00000123};
    tab[2]  = '{1,  16'hFFF0, 1'b1, 12'h801, 32'h00000FFF};
    tab[3]  = '{5,  16'h0008, 1'b1, 12'hA81, 32'h00000000};
    tab[4]  = '{2,  16'h5550, 1'b1, 12'h802, 32'h00000555};
    tab[5]  = '{2,  16'h6661, 1'b1, 12'hA82, 32'h00000666};
    tab[6]  = '{2,  16'h7770, 1'b1, 12'h803, 32'h00000777};
    tab[7]  = '{2,  16'h888F, 1'b1, 12'hA83, 32'h00000888};
    tab[8]  = '{2,  16'h9990, 1'b1, 12'h800, 32'h00000999};
    tab[9]  = '{2,  16'hAAA0, 1'b1, 12'hA80, 32'h00000AAA};
    tab[10] = '{0,  16'h1110, 1'b0, 12'h000, 32'h00000000};
    tab[11] = '{25, 16'hBBB0, 1'b1, 12'hA81, 32'h00000BBB};
    tab[12] = '{31, 16'hCCC0, 1'b0, 12'h000, 32'h00000000};
    tab[13] = '{4,  16'hDDD0, 1'b1, 12'hA82, 32'h00000DDD};
    tab[14] = '{3,  16'hEEE0, 1'b1, 12'h801, 32'h00000EEE};

    model_reset();
    force_lat = -1; tab_ptr = 0; use_tab = 1'b1;
    noise_en = 1'b0; clr_en = 1'b0; force_clr = 1'b0; cur_data = 16'h0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0;

    // Directed table: alternation, ring wrap, timeout, overrun, late drdy.
    for (int i = 0; i < 3000 && !(tab_ptr == NTAB && !busy); i++) run_one();
    chk("tab_done", 32'(tab_ptr == NTAB && !busy), 32'd1);
    chk("first_wen_cyc", 32'(first_wen), 32'd24);
    chk("ovr_set", 32'(ovr), 32'd1);
    chk("to_set", 32'(toe), 32'd1);
    force_clr = 1'b1; run_one(); force_clr = 1'b0;
    chk("ovr_cleared", 32'(ovr), 32'd0);
    chk("to_cleared", 32'(toe), 32'd0);

    // Reset while waiting for the DRP, with drdy arriving around the reset.
    noise_en = 1'b1; force_lat = 12;
    for (int i = 0; i < 100 && !(busy && cyc == den_cyc + 2); i++) run_one();
    chk("reach_wait", 32'(busy && cyc == den_cyc + 2), 32'd1);
    rst = 1'b1; drdy = 1'b1; clr = 1'b0;
    @(negedge clk);
    chk("mid_wen", 32'(wen), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0; model_reset();
    drdy = 1'b1;
    finish_cycle(1'b1);
    begin
      int k;
      k = 0;
      while (k < 100 && !(busy && cyc == den_cyc)) begin run_one(); k++; end
      chk("post_rst_chan", 32'(daddr), 32'h13);
    end

    // Randomized traffic: random latencies, spurious drdy, random clears.
    use_tab = 1'b0; clr_en = 1'b1;
    repeat (3000) run_one();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_adc_sample_sequencer
`default_nettype wire

// File: doc/adc_sample_sequencer.md
# adc_sample_sequencer

Paced XADC sampler that replaces the inline sample-control logic feeding the data RAM's ADC write-only port. On a fixed tick it alternates EMG (VAUX3) and ECG (VAUX11) reads over the XADC DRP. It then writes each 12-bit result into a per-channel ring buffer in data RAM. It publishes the ring head indices so the CPU and VGA path can locate the newest sample.

## Interface
- SAMPLE_INTERVAL, 175000: clocks between ticks (200 Hz at 35 MHz); must be ≥ 8.
- BUF_DEPTH, 640: entries per channel ring.
- EMG_BASE, 12'h800: RAM word address of EMG entry 0.
- ECG_BASE, 12'hA80: RAM word address of ECG entry 0.
- DRP_TIMEOUT, 255: max cycles to wait for drp_drdy.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clear_flags  in  1  clears overrun and timeout_err.
- drp_den  out  1  DRP read strobe, one-cycle pulse.
- drp_dwe  out  1  constant 0.
- drp_daddr  out  7  7'h13 (EMG) or 7'h1B (ECG); held from den until drdy or timeout.
- drp_do  in  16  DRP read data; result in [15:4].
- drp_drdy  in  1  DRP read-data valid.
- adc_wEn  out  1  RAM ADC-port write enable, one-cycle pulse.
- adc_addr  out  12  RAM write address.
- adc_dataIn  out  32  {20'b0, drp_do[15:4]}.
- emg_head  out  10  next EMG write index.
- ecg_head  out  10  next ECG write index.
- overrun  out  1  sticky: a tick arrived while the block was busy.
- timeout_err  out  1  sticky: a DRP read timed out.

## Operation
- Tick counter counts 0..SAMPLE_INTERVAL-1 and wraps. The tick asserts on the cycle the count equals SAMPLE_INTERVAL-1.
- FSM states: IDLE, REQ, WAIT, WRITE.
  - IDLE + tick -> REQ. The `chan` register selects the channel.
  - REQ: drp_den=1 for one cycle, then -> WAIT.
  - WAIT + drp_drdy: capture drp_do[15:4], then -> WRITE.
  - WAIT for DRP_TIMEOUT cycles without drdy: set timeout_err, toggle chan, -> IDLE. No write occurs and the head is unchanged.
  - WRITE: adc_wEn=1 with adc_addr = base(chan) + head(chan). Head increments and wraps from BUF_DEPTH-1 to 0. Toggle chan, then -> IDLE.
- After reset `chan` is EMG, so the first sample taken is EMG.
- A tick arriving outside IDLE sets overrun and is dropped. It does not toggle chan.
- drp_drdy outside WAIT is ignored.
- If clear_flags and a new flag event occur on the same cycle, the set wins.
- Address arithmetic is 12-bit unsigned. Parameters must satisfy base + BUF_DEPTH ≤ 4096 and ranges must not overlap; no wrap inside the adder.

## Timing
- Reset values:
  - counter 0, state IDLE, chan EMG.
  - drp_den 0, adc_wEn 0, adc_addr 0, adc_dataIn 0, drp_daddr 7'h13.
  - emg_head 0, ecg_head 0, overrun 0, timeout_err 0.
- Tick at cycle T: drp_den high at T+1.
- drdy at cycle D: adc_wEn high at D+1 and the head updates at the D+1 edge. For drdy latency L after den, den-to-wEn is L+1 cycles.
- adc_addr and adc_dataIn are registered and stay valid until the next write.
- Reset asserted mid-transaction returns to IDLE at the next edge. Any late drdy is ignored.
- The counter free-runs regardless of FSM state.

## Structure
- Package adc_pkg holds:
  - state enum.
  - DRP address constants EMG_DRP_ADDR=7'h13 and ECG_DRP_ADDR=7'h1B.
  - default bases and BUF_DEPTH.
  - the channel type.
- Sub-module sample_tick_gen (parameter INTERVAL) contains the counter and outputs `tick`.
- The FSM, head registers, and flags live in the top module.

## Test plan
- SAMPLE_INTERVAL=20, DRP model returns 16'hABC0 with L=3 -> first adc_wEn at cycle 24 after reset release. Expect addr 12'h800, data 32'h00000ABC, emg_head=1.
- Second tick -> drp_daddr 7'h1B, write to 12'hA80, ecg_head=1. Channels then strictly alternate.
- BUF_DEPTH=4, run 10 ticks -> EMG addresses 800,801,802,803,800. Head wraps 3->0.
- DRP model never asserts drdy, DRP_TIMEOUT=5 -> timeout_err=1 and no adc_wEn. The next tick samples ECG.
- DRP latency 25 with SAMPLE_INTERVAL=20 -> overrun=1 and the tick is dropped. clear_flags clears overrun the next cycle.
- Assert reset during WAIT, then drive drdy -> no adc_wEn and all outputs at reset values. The first post-reset sample is EMG.
